// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory copy/fill engine and its memory port.
package mem_pkg;
    localparam int MEM_N = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/mem_copy_engine_if.sv
// Byte-wide data memory port: address/write data from the initiator, read data back.
interface mem_copy_engine_if #(parameter int N = 16);
    logic           write_en;
    logic [N-1:0]   addr;
    logic [N-1:0]   datain;
    logic [N/2-1:0] dataout;

    modport master (output write_en, output addr, output datain, input dataout);
    modport slave  (input write_en, input addr, input datain, output dataout);
endinterface

// File: rtl/datamemory.sv
// Byte-wide RAM with registered read: address in cycle t, dataout valid in t+1.
module datamemory #(
    parameter int N = 16
) (
    input  logic                clk,
    mem_copy_engine_if.slave    mem
);
    localparam int B = N / 2;

    logic [B-1:0] ram [2**N];
    logic [B-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (mem.write_en)
            ram[mem.addr] <= mem.datain[B-1:0];
        dout_q <= ram[mem.addr];
    end

    assign mem.dataout = dout_q;
endmodule

// File: rtl/mem_copy_engine.sv
// Block COPY/FILL engine driving the byte-wide memory port; one command per start pulse.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int N = MEM_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [N-1:0]        src_addr,
    input  logic [N-1:0]        dst_addr,
    input  logic [N-1:0]        len,
    input  logic [N/2-1:0]      fill_val,
    output logic                busy,
    output logic                done,
    mem_copy_engine_if.master   mem
);
    localparam int B = N / 2;

    state_t       state, nxt;
    logic [N-1:0] idx, src_q, dst_q, len_q;
    logic [B-1:0] fill_q;
    logic         mode_q;
    logic         last;

    logic         we_c;
    logic [N-1:0] addr_c, din_c;

    assign last = (idx + N'(1)) == len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
            mode_q <= MODE_COPY;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                idx    <= '0;
                src_q  <= src_addr;
                dst_q  <= dst_addr;
                len_q  <= len;
                fill_q <= fill_val;
                mode_q <= mode;
            end else if (state == WRITE) begin
                idx <= idx + N'(1);
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:
                if (start) begin
                    if (len == '0)              nxt = DONE;
                    else if (mode == MODE_FILL) nxt = WRITE;
                    else                        nxt = READ;
                end
            READ:  nxt = WRITE;
            WRITE:
                if (last)                      nxt = DONE;
                else if (mode_q == MODE_FILL)  nxt = WRITE;
                else                           nxt = READ;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Moore outputs; address sums wrap modulo 2^N by width truncation.
    always_comb begin
        we_c   = 1'b0;
        addr_c = '0;
        din_c  = '0;
        case (state)
            READ: addr_c = src_q + idx;
            WRITE: begin
                we_c   = 1'b1;
                addr_c = dst_q + idx;
                din_c  = {{(N-B){1'b0}}, (mode_q == MODE_FILL) ? fill_q : mem.dataout};
            end
            default: ;
        endcase
    end

    assign busy         = (state == READ) || (state == WRITE);
    assign done         = (state == DONE);
    assign mem.write_en = we_c;
    assign mem.addr     = addr_c;
    assign mem.datain   = din_c;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed + randomized bench for mem_copy_engine against a byte-array reference model.
module tb_mem_copy_engine;
    import mem_pkg::*;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst, start, mode;
    logic [N-1:0]  src, dst, len;
    logic [7:0]    fill;
    logic          busy, done;

    mem_copy_engine_if #(.N(N)) mif ();

    mem_copy_engine #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src), .dst_addr(dst), .len(len), .fill_val(fill),
        .busy(busy), .done(done), .mem(mif)
    );

    datamemory #(.N(N)) u_mem (.clk(clk), .mem(mif));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] mdl [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mget(input int a);
        return mdl.exists(a) ? mdl[a] : 8'h00;
    endfunction

    // Issue one command and check every cycle against the model; spam=1 keeps
    // pulsing start with junk operands until the engine is back in IDLE.
    task automatic run(input logic m, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] l, input logic [7:0] f, input bit spam,
                       input string tag);
        int dc, widx, a;
        logic [15:0] exp_a[$];
        logic [7:0]  exp_d[$];
        dc = (l == 0) ? 1 : (m == MODE_FILL) ? int'(l) + 1 : 2 * int'(l) + 1;
        for (int i = 0; i < int'(l); i++) begin
            a = int'(16'(d + 16'(i)));
            exp_a.push_back(16'(a));
            exp_d.push_back((m == MODE_FILL) ? f : mget(int'(16'(s + 16'(i)))));
            mdl[a] = exp_d[$];
        end
        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill = f;
        widx = 0;
        for (int c = 1; c <= dc + 2; c++) begin
            @(negedge clk);
            start = spam && (c <= dc);
            mode = 1'($urandom); src = 16'($urandom); dst = 16'($urandom);
            len = 16'($urandom_range(0, 5)); fill = 8'($urandom);
            if (mif.write_en) begin
                if (widx < exp_a.size()) begin
                    chk({tag, " waddr"}, 32'(mif.addr), 32'(exp_a[widx]));
                    chk({tag, " wdata"}, 32'(mif.datain), {24'h0, exp_d[widx]});
                end else
                    chk({tag, " extra write"}, 32'(widx), 32'(exp_a.size()));
                widx++;
            end
            if (c == dc || c > dc) chk({tag, " busy"}, 32'(busy), 32'(0));
            if (c == dc || c == dc + 1) chk({tag, " done"}, 32'(done), 32'(c == dc));
            if (c == dc + 1) chk({tag, " idle addr"}, 32'(mif.addr), 32'(0));
            if (c == 1) chk({tag, " busy first"}, 32'(busy), 32'(l != 0));
        end
        start = 1'b0;
        chk({tag, " write count"}, 32'(widx), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < 32; i++)
            chk({tag, " ram"}, 32'(u_mem.ram[exp_a[i]]), 32'(mdl[int'(exp_a[i])]));
    endtask

    initial begin
        logic [15:0] base, s, d;
        logic [7:0]  v;
        rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset we", 32'(mif.write_en), 32'(0));
        chk("reset addr", 32'(mif.addr), 32'(0));
        chk("reset datain", 32'(mif.datain), 32'(0));
        rst = 1'b0;

        run(MODE_FILL, 16'h0, 16'h0100, 16'd4, 8'hA5, 1'b0, "T1 fill");
        run(MODE_FILL, 16'h0, 16'h0010, 16'd1, 8'd11, 1'b0, "T2 pre");
        run(MODE_FILL, 16'h0, 16'h0011, 16'd1, 8'd22, 1'b0, "T2 pre");
        run(MODE_FILL, 16'h0, 16'h0012, 16'd1, 8'd33, 1'b0, "T2 pre");
        run(MODE_COPY, 16'h0010, 16'h0200, 16'd3, 8'h00, 1'b0, "T2 copy");
        run(MODE_COPY, 16'h0010, 16'h0300, 16'd0, 8'h00, 1'b0, "T3 len0");
        run(MODE_FILL, 16'h0, 16'hFFFE, 16'd3, 8'h3C, 1'b0, "T4 wrap");
        chk("T4 ram0", 32'(u_mem.ram[0]), 32'h3C);
        for (int i = 0; i < 4; i++)
            run(MODE_FILL, 16'h0, 16'(i), 16'd1, 8'(i + 1), 1'b0, "T5 pre");
        run(MODE_COPY, 16'h0000, 16'h0001, 16'd3, 8'h00, 1'b0, "T5 overlap");
        for (int i = 0; i < 4; i++)
            chk("T5 ram", 32'(u_mem.ram[i]), 32'h01);

        // Start pulses while busy and during DONE must be ignored.
        run(MODE_FILL, 16'h0, 16'h0400, 16'd4, 8'h11, 1'b1, "T6 spam fill");
        run(MODE_COPY, 16'h0400, 16'h0500, 16'd3, 8'h00, 1'b1, "T6 spam copy");

        // Reset mid-command: only the first byte lands.
        run(MODE_FILL, 16'h0, 16'h0600, 16'd8, 8'h00, 1'b0, "T6 clear");
        @(negedge clk);
        start = 1'b1; mode = MODE_FILL; dst = 16'h0600; len = 16'd8; fill = 8'h77;
        @(negedge clk);
        start = 1'b0;
        chk("T6 first write", 32'(mif.write_en), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("T6 we after rst", 32'(mif.write_en), 32'(0));
        chk("T6 busy after rst", 32'(busy), 32'(0));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("T6 no done", 32'(done), 32'(0));
            chk("T6 no write", 32'(mif.write_en), 32'(0));
        end
        mdl[16'h0600] = 8'h77;
        chk("T6 ram0", 32'(u_mem.ram[16'h0600]), 32'h77);
        chk("T6 ram1", 32'(u_mem.ram[16'h0601]), 32'h00);

        // Random: preload 12 random bytes, then copy/fill around them.
        for (int it = 0; it < 6; it++) begin
            base = 16'($urandom);
            for (int i = 0; i < 12; i++) begin
                v = 8'($urandom);
                run(MODE_FILL, 16'h0, 16'(base + 16'(i)), 16'd1, v, 1'b0, "R pre");
            end
            s = 16'(base + 16'($urandom_range(0, 4)));
            d = (it % 2 == 0) ? 16'(base + 16'($urandom_range(0, 16))) : 16'($urandom);
            run(MODE_COPY, s, d, 16'($urandom_range(1, 8)), 8'h00, 1'($urandom), "R copy");
            run(MODE_FILL, 16'h0, 16'($urandom), 16'($urandom_range(0, 6)), 8'($urandom),
                1'($urandom), "R fill");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
